// File: rtl/iram_arb_pkg.sv
// Shared constants and helpers for the IRAM fetch arbiter and the reusable arbiter core.
package iram_arb_pkg;
    localparam int ADDR_W_DEF    = 16;
    localparam int DATA_W_DEF    = 16;
    localparam int NUM_CORES_DEF = 4;
    localparam int ARB_RR        = 0;
    localparam int ARB_FIXED     = 1;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = id_width(NUM_CORES_DEF);
endpackage

// File: rtl/iram_fetch_arbiter_rr.sv
// One-hot arbiter: round-robin from a rotating pointer, or fixed lowest-index priority.
module rr_arbiter
    import iram_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = ARB_RR,
    localparam int IW  = id_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  elig_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] win_id_o,
    output logic          accept_o
);
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  hi_mask;
    logic [N-1:0]  hi_elig;
    logic [N-1:0]  pick;
    logic [IW-1:0] win;

    // Bits at or above the pointer are searched first; wrap falls back to the whole vector.
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign hi_mask[gi] = (IW'(gi) >= ptr_q);
    end

    always_comb begin
        hi_elig = elig_i & hi_mask;
        if (MODE == ARB_FIXED || hi_elig == '0) begin
            pick = elig_i & (~elig_i + N'(1));
        end else begin
            pick = hi_elig & (~hi_elig + N'(1));
        end
    end

    always_comb begin
        win = '0;
        for (int i = 0; i < N; i++) begin
            if (pick[i]) begin
                win = win | IW'(i);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (MODE == ARB_FIXED) begin
            ptr_d = '0;
        end else if (|pick) begin
            ptr_d = (win == IW'(N - 1)) ? '0 : win + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt_o    = pick;
    assign win_id_o = win;
    assign accept_o = |pick;
endmodule

// File: rtl/iram_fetch_arbiter.sv
// Arbitrates core fetches onto the single-port IRAM and steers read data back to the winner.
module iram_fetch_arbiter
    import iram_arb_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ARB_MODE  = ARB_RR
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        core_en,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    output logic [NUM_CORES-1:0]        core_gnt,
    output logic [NUM_CORES-1:0]        core_rvalid,
    output logic [DATA_W-1:0]           core_rdata,
    output logic [ADDR_W-1:0]           iram_addr,
    output logic [DATA_W-1:0]           iram_data_in,
    input  logic [DATA_W-1:0]           iram_data_out
);
    localparam int IW = id_width(NUM_CORES);

    logic [NUM_CORES-1:0] elig;
    logic [NUM_CORES-1:0] gnt;
    logic [IW-1:0]        win_id;
    logic                 accept;
    logic [ADDR_W-1:0]    mux_addr;

    logic [ADDR_W-1:0] iram_addr_q, iram_addr_d;
    logic              s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic [IW-1:0]     s1_id_q, s1_id_d, s2_id_q, s2_id_d;

    // Gating elig during reset keeps the grant low without a separate output mask.
    assign elig = {NUM_CORES{rst_n}} & core_req & core_en;

    rr_arbiter #(
        .N    (NUM_CORES),
        .MODE (ARB_MODE)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .elig_i   (elig),
        .gnt_o    (gnt),
        .win_id_o (win_id),
        .accept_o (accept)
    );

    // AND-OR mux so an undriven address on a losing core cannot leak through.
    always_comb begin
        mux_addr = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            mux_addr = mux_addr | (core_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{gnt[i]}});
        end
    end

    always_comb begin
        iram_addr_d = accept ? mux_addr : iram_addr_q;
        s1_v_d      = accept;
        s1_id_d     = accept ? win_id : s1_id_q;
        s2_v_d      = s1_v_q;
        s2_id_d     = s1_id_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iram_addr_q <= '0;
            s1_v_q      <= 1'b0;
            s1_id_q     <= '0;
            s2_v_q      <= 1'b0;
            s2_id_q     <= '0;
        end else begin
            iram_addr_q <= iram_addr_d;
            s1_v_q      <= s1_v_d;
            s1_id_q     <= s1_id_d;
            s2_v_q      <= s2_v_d;
            s2_id_q     <= s2_id_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_rvalid
        assign core_rvalid[gi] = s2_v_q && (s2_id_q == IW'(gi));
    end

    assign core_gnt     = gnt;
    assign core_rdata   = iram_data_out;
    assign iram_addr    = iram_addr_q;
    assign iram_data_in = '0;
endmodule

// File: tb/tb_iram_fetch_arbiter.sv
// Bench for iram_fetch_arbiter: reference arbiter model plus response scoreboard, RR and fixed instances.
module tb_iram_fetch_arbiter;
    localparam int NC = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Round-robin instance
    logic [NC-1:0]    en, req, gnt, rvalid;
    logic [NC*AW-1:0] addr;
    logic [DW-1:0]    rdata, din, dout;
    logic [AW-1:0]    iaddr;

    // Fixed-priority instance
    logic [NC-1:0]    fx_en, fx_req, fx_gnt, fx_rvalid;
    logic [NC*AW-1:0] fx_addr;
    logic [DW-1:0]    fx_rdata, fx_din, fx_dout;
    logic [AW-1:0]    fx_iaddr;

    iram_fetch_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n), .core_en(en), .core_req(req), .core_addr(addr),
        .core_gnt(gnt), .core_rvalid(rvalid), .core_rdata(rdata),
        .iram_addr(iaddr), .iram_data_in(din), .iram_data_out(dout)
    );

    iram_fetch_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)) dut_fx (
        .clk(clk), .rst_n(rst_n), .core_en(fx_en), .core_req(fx_req), .core_addr(fx_addr),
        .core_gnt(fx_gnt), .core_rvalid(fx_rvalid), .core_rdata(fx_rdata),
        .iram_addr(fx_iaddr), .iram_data_in(fx_din), .iram_data_out(fx_dout)
    );

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        case (a)
            16'd0:   return 16'd35;
            16'd1:   return 16'd7;
            16'd2:   return 16'd6;
            16'd3:   return 16'd5;
            default: return 16'(a * 16'd3 + 16'd1);
        endcase
    endfunction

    // IRAM models: one-cycle registered read
    always @(posedge clk) begin
        dout    <= mem_f(iaddr);
        fx_dout <= mem_f(fx_iaddr);
    end

    typedef struct {
        int          due;
        int          id;
        logic [DW-1:0] data;
    } rsp_t;

    typedef struct {
        logic [NC-1:0] en;
        logic [NC-1:0] req;
        logic [NC-1:0] exp_gnt;
    } vec_t;

    rsp_t sb[$];
    vec_t tbl[10];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ptr_m   = 0;
    logic [AW-1:0] m_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock of the RR instance: compare against model at mid-cycle, then advance model state.
    task automatic step(output logic [NC-1:0] g, output logic [NC-1:0] rv);
        logic [NC-1:0] elig;
        logic [NC-1:0] exp_g;
        int w;
        rsp_t e;
        @(negedge clk);
        g  = gnt;
        rv = rvalid;
        elig = rst_n ? (req & en) : '0;
        w = -1;
        for (int k = 0; k < NC; k++) begin
            int idx;
            idx = (ptr_m + k) % NC;
            if (w < 0 && elig[idx]) w = idx;
        end
        exp_g = (w >= 0) ? NC'(1 << w) : '0;
        check("gnt", gnt, exp_g);
        check("iram_addr", iaddr, m_addr);
        check("iram_data_in", din, 0);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("rvalid", rvalid, 1 << e.id);
            check("rdata", rdata, e.data);
            $display("[TB] cyc %0d resp core %0d rdata %0d rvalid %b", cyc, e.id, rdata, rvalid);
        end else begin
            check("rvalid_idle", rvalid, 0);
        end
        if (!rst_n) begin
            ptr_m  = 0;
            m_addr = '0;
            sb.delete();
        end else if (w >= 0) begin
            e.due  = cyc + 2;
            e.id   = w;
            e.data = mem_f(addr[w*AW +: AW]);
            sb.push_back(e);
            m_addr = addr[w*AW +: AW];
            ptr_m  = (w + 1) % NC;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [NC-1:0] g, rv;
        int served;
        logic r1_seen, r2_seen;

        tbl[0] = '{4'hF, 4'b0001, 4'b0001};
        tbl[1] = '{4'hF, 4'b0000, 4'b0000};
        tbl[2] = '{4'hF, 4'b0000, 4'b0000};
        tbl[3] = '{4'hF, 4'b0000, 4'b0000};
        tbl[4] = '{4'hF, 4'b0100, 4'b0100};
        tbl[5] = '{4'hF, 4'b1010, 4'b1000};
        tbl[6] = '{4'hF, 4'b1010, 4'b0010};
        tbl[7] = '{4'hF, 4'b0000, 4'b0000};
        tbl[8] = '{4'hF, 4'b0000, 4'b0000};
        tbl[9] = '{4'hF, 4'b0000, 4'b0000};

        rst_n = 1'b0;
        en = '1; req = '0; addr = {16'd22, 16'd21, 16'd20, 16'd3};
        fx_en = '1; fx_req = '0; fx_addr = {16'd0, 16'd2, 16'd0, 16'd1};
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) step(g, rv);
        rst_n = 1'b1;

        // Single fetch followed by RR fairness after core 2
        for (int i = 0; i < 10; i++) begin
            en  = tbl[i].en;
            req = tbl[i].req;
            step(g, rv);
            check($sformatf("tbl_gnt[%0d]", i), g, tbl[i].exp_gnt);
        end

        // All cores requesting continuously out of reset; gnt forced low while in reset
        rst_n = 1'b0;
        req = '1;
        addr = {16'd3, 16'd2, 16'd1, 16'd0};
        for (int i = 0; i < 2; i++) begin
            step(g, rv);
            check("gnt_in_reset", g, 0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step(g, rv);
            check("all4_order", g, 1 << (k % NC));
        end
        req = '0;
        for (int i = 0; i < 3; i++) step(g, rv);

        // Disabled core 1 holds a request for 20 cycles
        en = 4'b1101;
        addr = {16'd40, 16'd41, 16'd10, 16'd42};
        served = 0;
        r1_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            req = 4'b0010 | (4'($urandom) & 4'b1101);
            step(g, rv);
            if (g[1] || rv[1]) r1_seen = 1'b1;
            if (g != '0) served++;
        end
        check("en_mask_core1", 32'(r1_seen), 0);
        check("en_mask_others_served", 32'(served > 0), 1);
        req = '0;
        for (int i = 0; i < 3; i++) step(g, rv);

        // Reset one cycle after an accept drops the fetch and restarts the search at core 0
        en = '1;
        addr = {16'd5, 16'd0, 16'd6, 16'd7};
        req = 4'b0100;
        step(g, rv);
        check("mid_accept", g, 4'b0100);
        r2_seen = 1'b0;
        rst_n = 1'b0;
        req = '0;
        step(g, rv);
        if (rv[2]) r2_seen = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(g, rv);
            if (rv[2]) r2_seen = 1'b1;
        end
        check("reset_drop_rvalid2", 32'(r2_seen), 0);
        req = '1;
        step(g, rv);
        check("post_reset_search", g, 4'b0001);
        req = '0;
        for (int i = 0; i < 3; i++) step(g, rv);
        check("sb_drained", sb.size(), 0);

        // Fixed priority: core 0 always beats core 2 until it drops its request
        fx_req = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("fx_gnt", fx_gnt, 4'b0001);
            if (k >= 2) begin
                check("fx_rvalid", fx_rvalid, 4'b0001);
                check("fx_rdata", fx_rdata, 16'd7);
                $display("[TB] fx cyc %0d resp core 0 rdata %0d", k, fx_rdata);
            end
            @(posedge clk);
            #1;
        end
        fx_req = 4'b0100;
        @(negedge clk);
        check("fx_gnt_after_drop", fx_gnt, 4'b0100);
        check("fx_rvalid_k6", fx_rvalid, 4'b0001);
        @(posedge clk);
        #1;
        fx_req = '0;
        @(negedge clk);
        check("fx_gnt_idle", fx_gnt, 0);
        check("fx_rvalid_k7", fx_rvalid, 4'b0001);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("fx_rvalid_core2", fx_rvalid, 4'b0100);
        check("fx_rdata_core2", fx_rdata, 16'd6);
        $display("[TB] fx resp core 2 rdata %0d", fx_rdata);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("fx_rvalid_end", fx_rvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/iram_fetch_arbiter.md
Name: iram_fetch_arbiter

Overview:
- Shares the single-port, read-only IRAM between the instruction-fetch units of NUM_CORES cores.
- Accepts at most one fetch per cycle using round-robin or fixed priority, and drives the IRAM address register.
- Tracks the winning core through the IRAM's one-cycle registered read and returns the data with a per-core valid.
- Sits between the core fetch stages and IRAM; IRAM's data_in is tied off here.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8)
- ADDR_W, 16, IRAM address width
- DATA_W, 16, instruction word width
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- core_en  in  NUM_CORES  per-core enable; a disabled core's req is ignored
- core_req  in  NUM_CORES  fetch request, held until accepted
- core_addr  in  NUM_CORES*ADDR_W  fetch addresses, core i at [i*ADDR_W +: ADDR_W]
- core_gnt  out  NUM_CORES  combinational accept; transfer happens on an edge where req&gnt
- core_rvalid  out  NUM_CORES  one-cycle pulse, instruction valid for that core
- core_rdata  out  DATA_W  instruction word, broadcast to all cores, qualified by core_rvalid
- iram_addr  out  ADDR_W  registered address to IRAM
- iram_data_in  out  DATA_W  constant 0
- iram_data_out  in  DATA_W  IRAM registered read data

Behaviour:
- Eligible vector elig = core_req & core_en.
- core_gnt is one-hot or zero. It is forced to 0 while rst_n = 0.
- RR mode:
  - Search starts at rr_ptr and wraps modulo NUM_CORES; first eligible core wins.
  - On an accept by core W, rr_ptr <= (W+1) mod NUM_CORES.
  - With no accept, rr_ptr holds.
- Fixed mode: lowest-index eligible core wins; rr_ptr is unused and stays 0.
- Pipeline (accept edge = end of cycle C):
  - C: core_gnt[W] = 1.
  - Edge C: iram_addr <= addr[W]; s1_v <= 1; s1_id <= W.
  - C+1: IRAM samples iram_addr at end of cycle.
  - Edge C+1: s2_v <= s1_v; s2_id <= s1_id.
  - C+2: core_rvalid[s2_id] = s2_v; core_rdata = iram_data_out.
- Latency: accept to rvalid is exactly 2 cycles. Throughput: 1 fetch/cycle. Responses return in accept order.
- No accept in a cycle: iram_addr holds its value; s1_v <= 0.
- Same core accepted on consecutive cycles (the only requester): allowed, with back-to-back rvalids.
- core_en deasserted while a fetch is in flight: the in-flight response is still delivered.
- Reset (rst_n = 0 at an edge):
  - iram_addr = 0, s1_v = s2_v = 0, s1_id = s2_id = 0, rr_ptr = 0.
  - core_rvalid = 0 from the next cycle onward; in-flight fetches are dropped.
  - core_rdata follows iram_data_out (don't-care).
- Unknown/X on core_addr of a non-granted core must not affect outputs.

Decomposition:
- Package iram_arb_pkg holds:
  - ADDR_W/DATA_W defaults
  - ID_W = $clog2(NUM_CORES)
  - ARB_RR / ARB_FIXED constants
- Sub-module rr_arbiter (parameter N, MODE): elig in, one-hot gnt out, internal rr_ptr, update on accept. Reused later for the data-RAM port.
- Top level holds the address mux, the s1/s2 id pipeline and the rvalid decode.

Test Plan:
- Single fetch: core 0 req addr 3 in cycle 1 -> gnt[0]=1 cycle 1; iram_addr=3 cycle 2; rvalid[0]=1, rdata=16'd5 (LDAC) cycle 3, then rvalid=0.
- All 4 cores req continuously from reset, addrs 0,1,2,3 -> gnt order 0,1,2,3,0,...; rvalid order 0,1,2,3 with rdata 35,7,6,5; one rvalid per cycle.
- RR fairness: last accept core 2, then cores 1 and 3 req -> core 3 wins; next cycle core 1 wins.
- Enable mask: core_en=4'b1101, core 1 req addr 10 held 20 cycles -> gnt[1] and rvalid[1] never asserted; other cores are served normally.
- Reset mid-flight: accept core 2 addr 0, rst_n=0 the next cycle for 1 cycle -> no rvalid[2] at any time; next accept after reset starts the search from core 0.
- ARB_MODE=1, cores 0 and 2 req continuously -> only core 0 granted; core 2 is granted in the first cycle after core 0 drops req.
